// File: rtl/definitions_pkg.sv
// Shared definitions for the UART receive path.
//   FIFO_WIDTH : data bits per UART frame, also the receive buffer word width
//   rx_state_t : receiver FSM states
package definitions_pkg;

  localparam int unsigned FIFO_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/rx_fifo.sv
// Circular receive buffer with first-word-fall-through read port.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   wr_en   : push wr_data (accepted when not full, or when a pop happens
//             in the same cycle)
//   wr_data : byte to push
//   rd_en   : pop the oldest entry (ignored when empty)
//   rd_data : oldest entry, valid whenever empty is low
//   empty   : no entries stored
//   full    : FIFO_DEPTH entries stored
module rx_fifo
  import definitions_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic w_rd_ok;
  logic w_wr_ok;

  always_comb begin
    empty   = (r_wr_ptr == r_rd_ptr);
    full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
              (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_rd_ok = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a push into a full buffer
    // is still accepted then.
    w_wr_ok = wr_en && (!full || w_rd_ok);
    rd_data = r_mem[r_rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr_ok) begin
        r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 8N1 deserialiser with a small receive buffer.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   rx        : asynchronous serial line, idle high
//   rd_en     : pop request, honoured only while rx_valid is high
//   rd_data   : oldest buffered byte (first-word-fall-through)
//   rx_valid  : buffer non-empty
//   frame_err : one-cycle pulse when a stop bit is sampled low
//   overrun   : one-cycle pulse when a good byte is dropped (buffer full)
//   busy      : receiver FSM not in IDLE
module uart_rx_core
  import definitions_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] rd_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(FIFO_WIDTH);
  localparam logic [CW-1:0] MID_START = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FIFO_WIDTH - 1);

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  w_rx;

  rx_state_t             r_state;
  rx_state_t             w_state_next;

  logic [CW-1:0]         r_clk_cnt;
  logic [BW-1:0]         r_bit_idx;
  logic [FIFO_WIDTH-1:0] r_shift;
  logic                  r_holdoff;
  logic                  r_frame_err;
  logic                  r_overrun;

  logic                  w_busy;
  logic                  w_cnt_clr;
  logic                  w_sample;
  logic                  w_stop_tick;
  logic                  w_push;
  logic                  w_ferr;
  logic                  w_empty;
  logic                  w_full;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        // After a framing error, wait for the line to be seen high before
        // treating a low level as a new start bit.
        if (!r_holdoff && !w_rx) w_state_next = START;
      end
      START: begin
        if (r_clk_cnt == MID_START) w_state_next = w_rx ? IDLE : DATA;
      end
      DATA: begin
        if (r_clk_cnt == BIT_END && r_bit_idx == LAST_BIT) w_state_next = STOP;
      end
      STOP: begin
        if (r_clk_cnt == BIT_END) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output / strobe logic.
  always_comb begin
    w_busy      = (r_state != IDLE);
    w_sample    = (r_state == DATA) && (r_clk_cnt == BIT_END);
    w_stop_tick = (r_state == STOP) && (r_clk_cnt == BIT_END);
    w_push      = w_stop_tick && w_rx;
    w_ferr      = w_stop_tick && !w_rx;
    // Counter restarts on every state change and at each data-bit boundary.
    w_cnt_clr   = (w_state_next != r_state) || w_sample;
  end

  // Bit timing, shift register and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_holdoff   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_cnt_clr || r_state == IDLE) begin
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + CW'(1);
      end

      if (r_state != DATA) begin
        r_bit_idx <= '0;
      end else if (w_sample) begin
        r_bit_idx <= r_bit_idx + BW'(1);
      end

      // LSB arrives first, so shift right and insert at the MSB.
      if (w_sample) begin
        r_shift <= {w_rx, r_shift[FIFO_WIDTH-1:1]};
      end

      if (w_ferr) begin
        r_holdoff <= 1'b1;
      end else if (r_state == IDLE && w_rx) begin
        r_holdoff <= 1'b0;
      end

      r_frame_err <= w_ferr;
      r_overrun   <= w_push && w_full && !(rd_en && !w_empty);
    end
  end

  rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (w_push),
    .wr_data(r_shift),
    .rd_en  (rd_en),
    .rd_data(rd_data),
    .empty  (w_empty),
    .full   (w_full)
  );

  assign rx_valid  = !w_empty;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = w_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit, 4-entry buffer.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int busy_cnt = 0;
  int both_cnt = 0;

  uart_rx_core #(
    .CLKS_PER_BIT(16),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (busy) busy_cnt++;
    if (frame_err && overrun) both_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Drives one 160-cycle frame; the line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int c = 0; c < 160; c++) begin
      rx = f[c/16];
      @(posedge clk); #1;
    end
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    idle_cycles(4);
  endtask

  task automatic test_basic();
    logic [9:0] f;
    fe_cnt = 0; ov_cnt = 0;
    f = {1'b1, 8'hA5, 1'b0};
    for (int c = 0; c < 160; c++) begin
      rx = f[c/16];
      if (c == 154) begin
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", rx_valid); end
      end
      if (c == 155) begin
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_latency got=%b exp=1", rx_valid); end
        total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", rd_data); end
      end
      @(posedge clk); #1;
    end
    total++; if (fe_cnt !== 0) begin bad++; $display("FAIL basic_frame_err got=%0d exp=0", fe_cnt); end
    total++; if (ov_cnt !== 0) begin bad++; $display("FAIL basic_overrun got=%0d exp=0", ov_cnt); end
    pop();
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL basic_after_pop got=%b exp=0", rx_valid); end
    pop();
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL empty_pop_valid got=%b exp=0", rx_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL empty_pop_busy got=%b exp=0", busy); end
  endtask

  task automatic test_glitch();
    idle_cycles(4);
    fe_cnt = 0; busy_cnt = 0;
    rx = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    idle_cycles(30);
    total++; if (busy_cnt > 8 || busy_cnt == 0) begin bad++; $display("FAIL glitch_busy_cycles got=%0d exp=1..8", busy_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_push got=%b exp=0", rx_valid); end
    total++; if (fe_cnt !== 0) begin bad++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt); end
  endtask

  task automatic test_frame_err();
    fe_cnt = 0; ov_cnt = 0;
    send_frame(8'h3C, 1'b0);
    busy_cnt = 0;
    rx = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    total++; if (fe_cnt !== 1) begin bad++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt); end
    total++; if (ov_cnt !== 0) begin bad++; $display("FAIL ferr_overrun got=%0d exp=0", ov_cnt); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ferr_buffer got=%b exp=0", rx_valid); end
    total++; if (busy_cnt !== 0) begin bad++; $display("FAIL ferr_holdoff_busy got=%0d exp=0", busy_cnt); end
    idle_cycles(4);
    send_frame(8'h5A, 1'b1);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ferr_recover_valid got=%b exp=1", rx_valid); end
    total++; if (rd_data !== 8'h5A) begin bad++; $display("FAIL ferr_recover_data got=%h exp=5a", rd_data); end
    pop();
  endtask

  task automatic test_overrun();
    logic [7:0] exp_b;
    idle_cycles(4);
    fe_cnt = 0; ov_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      exp_b = 8'(i);
      send_frame(exp_b, 1'b1);
    end
    total++; if (ov_cnt !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d exp=1", ov_cnt); end
    total++; if (fe_cnt !== 0) begin bad++; $display("FAIL ovr_frame_err got=%0d exp=0", fe_cnt); end
    for (int i = 1; i <= 4; i++) begin
      exp_b = 8'(i);
      total++; if (rx_valid !== 1'b1 || rd_data !== exp_b) begin
        bad++; $display("FAIL ovr_read%0d got=%h/%b exp=%h/1", i, rd_data, rx_valid, exp_b);
      end
      pop();
    end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_drained got=%b exp=0", rx_valid); end
  endtask

  task automatic test_full_pushpop();
    logic [9:0] f;
    logic [7:0] exp_q [4];
    idle_cycles(4);
    send_frame(8'h10, 1'b1);
    send_frame(8'h11, 1'b1);
    send_frame(8'h12, 1'b1);
    send_frame(8'h13, 1'b1);
    fe_cnt = 0; ov_cnt = 0;
    f = {1'b1, 8'h77, 1'b0};
    for (int c = 0; c < 160; c++) begin
      rx = f[c/16];
      rd_en = (c == 154);
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
    total++; if (ov_cnt !== 0) begin bad++; $display("FAIL full_pp_overrun got=%0d exp=0", ov_cnt); end
    exp_q[0] = 8'h11; exp_q[1] = 8'h12; exp_q[2] = 8'h13; exp_q[3] = 8'h77;
    for (int i = 0; i < 4; i++) begin
      total++; if (rx_valid !== 1'b1 || rd_data !== exp_q[i]) begin
        bad++; $display("FAIL full_pp_read%0d got=%h/%b exp=%h/1", i, rd_data, rx_valid, exp_q[i]);
      end
      pop();
    end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL full_pp_drained got=%b exp=0", rx_valid); end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] f;
    idle_cycles(4);
    f = {1'b1, 8'hFF, 1'b0};
    for (int c = 0; c < 88; c++) begin
      rx = f[c/16];
      @(posedge clk); #1;
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || rx_valid !== 1'b0 || rd_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL mid_rst_outputs got busy=%b valid=%b data=%h fe=%b ov=%b exp=0/0/00/0/0",
                      busy, rx_valid, rd_data, frame_err, overrun);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    fe_cnt = 0; ov_cnt = 0;
    idle_cycles(10);
    send_frame(8'h12, 1'b1);
    total++; if (rx_valid !== 1'b1 || rd_data !== 8'h12) begin
      bad++; $display("FAIL mid_new_frame got=%h/%b exp=12/1", rd_data, rx_valid);
    end
    pop();
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL mid_only_one got=%b exp=0", rx_valid); end
    total++; if (fe_cnt !== 0 || ov_cnt !== 0) begin bad++; $display("FAIL mid_flags got fe=%0d ov=%0d exp=0/0", fe_cnt, ov_cnt); end
  endtask

  task automatic test_exclusive();
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL flags_exclusive got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_pushpop();
    test_reset_midframe();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
